// File: rtl/strobe_gen_pkg.sv
// Shared types and helpers for the strobe generator: FSM state encoding and ratio clamping.
package strobe_gen_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // A request of 0 runs at one read per period; anything above lim runs at lim.
  function automatic int unsigned clamp_ratio(int unsigned sel, int unsigned lim);
    if (sel == 0) return 1;
    if (sel > lim) return lim;
    return sel;
  endfunction

endpackage

// File: rtl/strobe_generator_if.sv
// Control and strobe bundle between a requester (master) and the strobe generator (slave).
interface strobe_generator_if #(
  parameter int unsigned Period   = 8,
  parameter int unsigned MaxRatio = 4
);
  localparam int unsigned PhaseW = $clog2(Period);
  localparam int unsigned RatioW = $clog2(MaxRatio + 1);

  logic              enable;
  logic [RatioW-1:0] ratioSel;
  logic              writeEn;
  logic              readEn;
  logic [RatioW-1:0] readIndex;
  logic [PhaseW-1:0] phase;
  logic [RatioW-1:0] ratioActive;
  logic              locked;
  logic              ratioClamped;

  modport master (
    output enable, ratioSel,
    input  writeEn, readEn, readIndex, phase, ratioActive, locked, ratioClamped
  );

  modport slave (
    input  enable, ratioSel,
    output writeEn, readEn, readIndex, phase, ratioActive, locked, ratioClamped
  );

endinterface

// File: rtl/strobe_generator_accumulator.sv
// Bresenham read spreader: emits ratio_i evenly spaced read strobes per period, registered so
// they line up with the phase reported in the same cycle.
module phase_accumulator #(
  parameter int unsigned Period   = 8,
  parameter int unsigned MaxRatio = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               run_i,
  input  logic                               restart_i,
  input  logic [$clog2(MaxRatio + 1)-1:0]    ratio_i,
  output logic                               read_en_o,
  output logic [$clog2(MaxRatio + 1)-1:0]    read_index_o
);
  localparam int unsigned AccW   = $clog2(2 * Period);
  localparam int unsigned RatioW = $clog2(MaxRatio + 1);
  localparam logic [AccW-1:0] PeriodA = AccW'(Period);

  logic [AccW-1:0]   acc_q, acc_d;
  logic              read_en_q, read_en_d;
  logic [RatioW-1:0] read_index_q, read_index_d;
  logic [AccW-1:0]   base, sum;

  // acc_q holds the remainder after the displayed cycle; sum covers the upcoming cycle.
  always_comb begin
    base         = restart_i ? '0 : acc_q;
    sum          = base + AccW'(ratio_i);
    acc_d        = '0;
    read_en_d    = 1'b0;
    read_index_d = '0;
    if (run_i) begin
      read_en_d    = (sum >= PeriodA);
      acc_d        = read_en_d ? (sum - PeriodA) : sum;
      read_index_d = restart_i ? '0 : (read_index_q + RatioW'(read_en_q));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q        <= '0;
      read_en_q    <= 1'b0;
      read_index_q <= '0;
    end else begin
      acc_q        <= acc_d;
      read_en_q    <= read_en_d;
      read_index_q <= read_index_d;
    end
  end

  assign read_en_o    = read_en_q;
  assign read_index_o = read_index_q;

endmodule

// File: rtl/strobe_generator.sv
// Single-clock write/read strobe generator: one write strobe per period plus a sampled number
// of evenly spread read strobes, with phase, ratio and lock reporting.
module strobe_generator
  import strobe_gen_pkg::*;
#(
  parameter int unsigned Period      = 8,
  parameter int unsigned MaxRatio    = 4,
  parameter int unsigned LockPeriods = 2
) (
  input logic               mainClk,
  input logic               resetN,
  strobe_generator_if.slave bus
);
  localparam int unsigned PhaseW   = $clog2(Period);
  localparam int unsigned RatioW   = $clog2(MaxRatio + 1);
  localparam int unsigned RatioLim = (MaxRatio < Period) ? MaxRatio : Period;
  localparam int unsigned LockW    = $clog2(LockPeriods + 1);
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(Period - 1);
  localparam logic [LockW-1:0]  LockMax   = LockW'(LockPeriods);

  state_e            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic              write_en_q, write_en_d;
  logic [RatioW-1:0] ratio_active_q, ratio_active_d;
  logic              ratio_clamped_q, ratio_clamped_d;
  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;

  logic              wrap, restart, sel_clamped;
  logic [RatioW-1:0] sel_ratio;

  assign sel_ratio   = RatioW'(clamp_ratio(32'(bus.ratioSel), RatioLim));
  assign sel_clamped = (bus.ratioSel == '0) || (32'(bus.ratioSel) > RatioLim);
  assign wrap        = (state_q == StRun) && (phase_q == LastPhase);
  // Next cycle starts a period: either entering RUN or wrapping.
  assign restart     = (state_q == StIdle) || wrap;

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    write_en_d      = 1'b0;
    ratio_active_d  = ratio_active_q;
    ratio_clamped_d = ratio_clamped_q;
    lock_cnt_d      = lock_cnt_q;
    locked_d        = locked_q;
    if (!bus.enable) begin
      state_d    = StIdle;
      phase_d    = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      state_d    = StRun;
      phase_d    = restart ? '0 : (phase_q + PhaseW'(1));
      write_en_d = restart;
      if (restart) begin
        ratio_active_d  = sel_ratio;
        ratio_clamped_d = sel_clamped;
        if ((state_q == StRun) && (sel_ratio == ratio_active_q)) begin
          if (lock_cnt_q != LockMax) lock_cnt_d = lock_cnt_q + LockW'(1);
        end else begin
          lock_cnt_d = '0;
        end
        locked_d = (lock_cnt_d == LockMax);
      end
    end
  end

  always_ff @(posedge mainClk) begin
    if (!resetN) begin
      state_q         <= StIdle;
      phase_q         <= '0;
      write_en_q      <= 1'b0;
      ratio_active_q  <= RatioW'(1);
      ratio_clamped_q <= 1'b0;
      lock_cnt_q      <= '0;
      locked_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      write_en_q      <= write_en_d;
      ratio_active_q  <= ratio_active_d;
      ratio_clamped_q <= ratio_clamped_d;
      lock_cnt_q      <= lock_cnt_d;
      locked_q        <= locked_d;
    end
  end

  phase_accumulator #(
    .Period   (Period),
    .MaxRatio (MaxRatio)
  ) u_phase_accumulator (
    .clk_i        (mainClk),
    .rst_ni       (resetN),
    .run_i        (bus.enable),
    .restart_i    (restart),
    .ratio_i      (ratio_active_d),
    .read_en_o    (bus.readEn),
    .read_index_o (bus.readIndex)
  );

  assign bus.writeEn      = write_en_q;
  assign bus.phase        = phase_q;
  assign bus.ratioActive  = ratio_active_q;
  assign bus.locked       = locked_q;
  assign bus.ratioClamped = ratio_clamped_q;

endmodule

// File: tb/tb_strobe_generator.sv
// Directed and randomised bench for strobe_generator; a cycle model feeds a scoreboard queue.
module tb_strobe_generator;

  typedef struct {
    logic       we;
    logic       re;
    logic [2:0] ri;
    logic       chk_ri;
    logic [2:0] ph;
    logic [2:0] ra;
    logic       lk;
    logic       cl;
  } exp_t;

  logic mainClk = 1'b0;
  logic resetN;
  always #5 mainClk = ~mainClk;

  strobe_generator_if #(.Period(8), .MaxRatio(4)) bus ();

  strobe_generator #(
    .Period      (8),
    .MaxRatio    (4),
    .LockPeriods (2)
  ) dut (
    .mainClk (mainClk),
    .resetN  (resetN),
    .bus     (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Reference state after the most recent edge.
  bit m_run;
  int m_phase, m_ratio, m_cnt;
  bit m_locked, m_clamped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rstn, input logic en, input int sel);
    int r;
    bit samp;
    if (!rstn) begin
      m_run = 0; m_phase = 0; m_ratio = 1; m_clamped = 0; m_cnt = 0; m_locked = 0;
    end else if (!en) begin
      m_run = 0; m_phase = 0; m_cnt = 0; m_locked = 0;
    end else begin
      r    = (sel == 0) ? 1 : ((sel > 4) ? 4 : sel);
      samp = !m_run || (m_phase == 7);
      if (samp) begin
        if (m_run && (r == m_ratio)) m_cnt = (m_cnt < 2) ? m_cnt + 1 : 2;
        else m_cnt = 0;
        m_locked  = (m_cnt >= 2);
        m_clamped = (sel == 0) || (sel > 4);
        m_ratio   = r;
      end
      m_phase = (m_run && (m_phase != 7)) ? m_phase + 1 : 0;
      m_run   = 1;
    end
  endtask

  // One clock: drive at negedge, predict, then compare just after the rising edge.
  task automatic step(input logic rstn, input logic en, input int sel);
    exp_t e;
    @(negedge mainClk);
    resetN       = rstn;
    bus.enable   = en;
    bus.ratioSel = 3'(sel);
    model_edge(rstn, en, sel);
    e.we     = m_run && (m_phase == 0);
    // Reads fall where floor(p*r/8) steps up; the read ordinal is that floor.
    e.re     = m_run && ((((m_phase + 1) * m_ratio) / 8) > ((m_phase * m_ratio) / 8));
    e.ri     = 3'((m_phase * m_ratio) / 8);
    e.chk_ri = e.re || !rstn;
    e.ph     = 3'(m_phase);
    e.ra     = 3'(m_ratio);
    e.lk     = m_locked;
    e.cl     = m_clamped;
    sb_q.push_back(e);
    @(posedge mainClk);
    #1;
    e = sb_q.pop_front();
    chk("writeEn", 32'(bus.writeEn), 32'(e.we));
    chk("readEn", 32'(bus.readEn), 32'(e.re));
    if (e.chk_ri) chk("readIndex", 32'(bus.readIndex), 32'(e.ri));
    chk("phase", 32'(bus.phase), 32'(e.ph));
    chk("ratioActive", 32'(bus.ratioActive), 32'(e.ra));
    chk("locked", 32'(bus.locked), 32'(e.lk));
    chk("ratioClamped", 32'(bus.ratioClamped), 32'(e.cl));
  endtask

  task automatic run_period(input int sel_a, input int sel_b, input int split,
                            output logic [7:0] rd, output logic [7:0] lk,
                            output logic [2:0] ra0, output logic cl0, output logic we0);
    rd = '0;
    lk = '0;
    ra0 = '0;
    cl0 = 1'b0;
    we0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, (i < split) ? sel_a : sel_b);
      rd[i] = bus.readEn;
      lk[i] = bus.locked;
      if (i == 0) begin
        ra0 = bus.ratioActive;
        cl0 = bus.ratioClamped;
        we0 = bus.writeEn;
      end
    end
  endtask

  initial begin
    logic [7:0] rd, lk;
    logic [2:0] ra;
    logic       cl, we;
    resetN       = 1'b0;
    bus.enable   = 1'b0;
    bus.ratioSel = '0;

    // Reset, including reset held while enable is high.
    step(1'b0, 1'b0, 2);
    step(1'b0, 1'b1, 2);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    chk("rst_ratioActive", 32'(bus.ratioActive), 32'd1);
    chk("rst_locked", 32'(bus.locked), 32'd0);

    // Ratio 2: reads at phases 3 and 7, lock at the third phase 0.
    run_period(2, 2, 8, rd, lk, ra, cl, we);
    chk("s1_we0", 32'(we), 32'd1);
    chk("s1_reads", 32'(rd), 32'h88);
    chk("s3_lock_p1", 32'(lk), 32'h00);
    run_period(2, 2, 8, rd, lk, ra, cl, we);
    chk("s3_lock_p2", 32'(lk), 32'h00);
    run_period(2, 2, 8, rd, lk, ra, cl, we);
    chk("s3_lock_p3", 32'(lk), 32'hFF);
    chk("s1_reads_p3", 32'(rd), 32'h88);

    // Read spacing for ratios 3, 4 and 1.
    run_period(3, 3, 8, rd, lk, ra, cl, we);
    chk("s2_reads_r3", 32'(rd), 32'hA4);
    chk("s2_unlock_r3", 32'(lk), 32'h00);
    run_period(4, 4, 8, rd, lk, ra, cl, we);
    chk("s2_reads_r4", 32'(rd), 32'hAA);
    run_period(1, 1, 8, rd, lk, ra, cl, we);
    chk("s2_reads_r1", 32'(rd), 32'h80);

    // Mid-period ratio change 2 -> 4 takes effect only at the next phase 0.
    for (int p = 0; p < 3; p++) run_period(2, 2, 8, rd, lk, ra, cl, we);
    chk("s4_locked_before", 32'(lk), 32'hFF);
    run_period(2, 4, 4, rd, lk, ra, cl, we);
    chk("s4_reads_change", 32'(rd), 32'h88);
    chk("s4_ratio_change", 32'(ra), 32'd2);
    run_period(4, 4, 8, rd, lk, ra, cl, we);
    chk("s4_ratio_new", 32'(ra), 32'd4);
    chk("s4_unlock", 32'(lk), 32'h00);
    run_period(4, 4, 8, rd, lk, ra, cl, we);
    chk("s4_unlock2", 32'(lk), 32'h00);
    run_period(4, 4, 8, rd, lk, ra, cl, we);
    chk("s4_relock", 32'(lk), 32'hFF);

    // Clamping of out-of-range requests.
    run_period(0, 0, 8, rd, lk, ra, cl, we);
    chk("s5_ratio0", 32'(ra), 32'd1);
    chk("s5_clamp0", 32'(cl), 32'd1);
    run_period(7, 7, 8, rd, lk, ra, cl, we);
    chk("s5_ratio7", 32'(ra), 32'd4);
    chk("s5_clamp7", 32'(cl), 32'd1);
    chk("s5_reads7", 32'(rd), 32'hAA);
    run_period(2, 2, 8, rd, lk, ra, cl, we);
    chk("s5_unclamp", 32'(cl), 32'd0);

    // Enable dropped at phase 5, then one idle cycle and restart.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 2);
    chk("s6_phase5", 32'(bus.phase), 32'd5);
    step(1'b1, 1'b0, 2);
    chk("s6_drop_phase", 32'(bus.phase), 32'd0);
    chk("s6_drop_strobes", 32'({bus.writeEn, bus.readEn}), 32'd0);
    chk("s6_drop_locked", 32'(bus.locked), 32'd0);
    step(1'b1, 1'b1, 2);
    chk("s6_reenable_we", 32'(bus.writeEn), 32'd1);

    // Reset pulsed at phase 4.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2);
    chk("s6_phase4", 32'(bus.phase), 32'd4);
    step(1'b0, 1'b1, 2);
    chk("s6_rst_phase", 32'(bus.phase), 32'd0);
    chk("s6_rst_strobes", 32'({bus.writeEn, bus.readEn}), 32'd0);
    step(1'b1, 1'b1, 3);
    chk("s6_rst_reenable_we", 32'(bus.writeEn), 32'd1);

    // Enable falls at phase 7: no ratio sample on that edge.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 3);
    step(1'b1, 1'b0, 4);
    chk("edge_no_sample", 32'(bus.ratioActive), 32'd3);
    step(1'b1, 1'b1, 1);
    chk("edge_resample", 32'(bus.ratioActive), 32'd1);

    // Randomised traffic checked against the model every cycle.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 15) != 0),
           int'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/strobe_generator.md
Name: strobe_generator

Overview:
- Parametrised successor to the DCM-based write/read clock pair. It runs entirely on mainClk and produces clock-enable strobes instead of derived clocks.
- Per write period of PERIOD mainClk cycles it issues one writeEn and a runtime-selectable number of evenly spread readEn strobes. It also reports the phase and read index, and a locked indication.
- It feeds the line-buffer write/read ports of the neighbourhood pipeline; all consumers stay on mainClk.

Parameters:
- PERIOD, 8, mainClk cycles per write period (>=2).
- MAX_RATIO, 4, maximum read strobes per write period (1..PERIOD).
- LOCK_PERIODS, 2, complete periods at a stable ratio before locked asserts (>=1).
- PHASE_W, $clog2(PERIOD), phase counter width (localparam).
- RATIO_W, $clog2(MAX_RATIO+1), ratio field width (localparam).

Ports:
- mainClk  in  1  system clock; all logic is on its rising edge.
- resetN  in  1  synchronous, active-low reset.
- enable  in  1  run request; low parks the generator.
- ratioSel  in  RATIO_W  requested read strobes per period.
- writeEn  out  1  one-cycle write strobe, once per period at phase 0.
- readEn  out  1  read strobe, ratioActive pulses per period.
- readIndex  out  RATIO_W  ordinal (0-based) of the current read within the period; valid with readEn.
- phase  out  PHASE_W  current position in the period, 0..PERIOD-1.
- ratioActive  out  RATIO_W  ratio currently in effect.
- locked  out  1  stable operation indication.
- ratioClamped  out  1  ratioSel was out of range at the last sample; sticky until the next sample.

Behaviour:
- All outputs are registered. Output values below refer to the same cycle as the phase value shown.
- Reset (resetN=0 at an edge): phase=0, writeEn=0, readEn=0, readIndex=0, locked=0, ratioClamped=0, ratioActive=1, accumulator=0, lock counter=0. Reset overrides every other input, including mid-period.
- States: IDLE, RUN.
- IDLE: all strobes 0, phase=0, locked=0.
  - enable=1 moves to RUN. The first RUN cycle has phase=0 and writeEn=1, i.e. 1 cycle after enable is sampled high.
- RUN: phase increments by 1 each cycle and wraps PERIOD-1 -> 0. writeEn=1 exactly when phase==0.
  - enable=0 sampled in any RUN cycle forces IDLE on the next cycle, even mid-period. No further strobes; locked drops in the same cycle.
- Read spacing uses a Bresenham accumulator acc, width clog2(2*PERIOD):
  - Each RUN cycle: s = acc + ratioActive.
  - If s >= PERIOD: readEn=1 and acc <= s - PERIOD; otherwise readEn=0 and acc <= s.
  - acc is 0 at every phase 0, so exactly ratioActive reads occur per period.
  - readIndex counts reads from 0 within the period and returns to 0 at phase 0.
- Ratio sampling: ratioSel is sampled only on the IDLE->RUN transition and on each PERIOD-1 -> 0 wrap. It never changes mid-period.
  - ratioSel=0 is treated as 1. ratioSel > min(MAX_RATIO, PERIOD) is treated as that limit.
  - In either clamp case ratioClamped=1 from that phase 0 until the next sample.
- Lock:
  - The lock counter increments at each wrap where the sampled ratio equals ratioActive.
  - locked=1 from the phase-0 cycle that ends LOCK_PERIODS complete periods.
  - A sampled ratio change updates ratioActive, clears the counter and locked at that phase 0, and relocks after LOCK_PERIODS further periods.
  - Leaving RUN clears both counter and locked.
- Simultaneous events:
  - enable falling at phase PERIOD-1: IDLE wins; no ratio sample occurs.
  - Resynchronisation: enable low for one cycle then high gives IDLE for one cycle, then RUN restarts at phase 0.

Decomposition:
- Package strobe_gen_pkg holds the state enum {IDLE, RUN} and a clamp-ratio function.
- One sub-module, phase_accumulator, implements the Bresenham acc/readEn/readIndex logic with PERIOD and MAX_RATIO parameters. The top level holds the FSM, phase counter, ratio sampling and lock counter.

Test Plan:
All scenarios use default parameters (PERIOD=8, MAX_RATIO=4, LOCK_PERIODS=2).
1. Reset, enable=1, ratioSel=2 -> writeEn at phase 0; readEn at phases 3,7 with readIndex 0,1; pattern repeats every 8 cycles.
2. ratioSel=3 -> reads at phases 2,5,7. ratioSel=4 -> reads at 1,3,5,7. ratioSel=1 -> read at phase 7 only.
3. Enable at ratio 2 -> locked=0 for the first 16 RUN cycles, rises at the third phase 0, then stays 1.
4. ratioSel changed 2->4 at phase 3 -> remaining reads in that period still at phase 7. At the next phase 0: ratioActive=4 and locked=0; locked returns 16 cycles later.
5. ratioSel=0 and then 7 -> ratioActive=1 and 4 respectively, with ratioClamped=1 from the following phase 0.
6. enable dropped at phase 5, and separately resetN pulsed at phase 4 -> no strobes on the next cycle, phase=0, locked=0. On re-enable the next RUN cycle has writeEn=1 at phase 0.
